// File: rtl/display_pkg.sv
// Shared opcodes, geometry defaults and decoder state type for the display receiver.
package display_pkg;

  localparam int unsigned COLS_DEF  = 128;
  localparam int unsigned PAGES_DEF = 8;

  localparam logic [7:0] OP_DISP_OFF  = 8'hAE;
  localparam logic [7:0] OP_DISP_ON   = 8'hAF;
  localparam logic [7:0] OP_COL_ADDR  = 8'h21;
  localparam logic [7:0] OP_PAGE_ADDR = 8'h22;

  localparam int unsigned N_ONE_ARG = 9;
  localparam logic [7:0] OP_ONE_ARG [N_ONE_ARG] =
    '{8'h20, 8'h81, 8'h8D, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB};

  typedef enum logic {ST_CMD, ST_ARG} dec_state_t;

  function automatic logic is_one_arg(input logic [7:0] op);
    logic hit;
    hit = 1'b0;
    for (int unsigned i = 0; i < N_ONE_ARG; i++)
      if (op == OP_ONE_ARG[i]) hit = 1'b1;
    return hit;
  endfunction

endpackage

// File: rtl/spi_deserializador.sv
// Synchronizes the serial display inputs, detects sclk rising edges and assembles
// MSB-first bytes; flags bytes cut short by chip-select release.
module spi_deserializador #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       io_sclk,
  input  logic       io_sdin,
  input  logic       io_cs,
  input  logic       io_dc,
  input  logic       io_reset,
  output logic       reset_n_s,
  output logic       done,
  output logic [7:0] done_byte,
  output logic       done_dc,
  output logic [7:0] rx_byte,
  output logic       rx_dc,
  output logic       rx_valid,
  output logic       err_pulse
);

  // vector order {reset, cs, dc, sdin, sclk}; idle reset/cs are high
  localparam logic [4:0] SYNC_RST = 5'b11000;

  logic [SYNC_STAGES-1:0][4:0] sync_q;
  logic       sclk_s, sdin_s, dc_s, cs_s;
  logic       sclk_d, cs_d;
  logic       sclk_rise, cs_rise, cs_fall, shift_en;
  logic [6:0] shreg;
  logic [2:0] bit_cnt;

  assign sclk_s    = sync_q[SYNC_STAGES-1][0];
  assign sdin_s    = sync_q[SYNC_STAGES-1][1];
  assign dc_s      = sync_q[SYNC_STAGES-1][2];
  assign cs_s      = sync_q[SYNC_STAGES-1][3];
  assign reset_n_s = sync_q[SYNC_STAGES-1][4];

  assign sclk_rise = sclk_s & ~sclk_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign cs_fall   = ~cs_s & cs_d;
  // an edge coinciding with cs release still belongs to the selected transfer
  assign shift_en  = sclk_rise & (~cs_s | ~cs_d);
  assign done      = shift_en & (bit_cnt == 3'd7) & reset_n_s;
  assign done_byte = {shreg, sdin_s};
  assign done_dc   = dc_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= {SYNC_STAGES{SYNC_RST}};
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
      shreg     <= '0;
      bit_cnt   <= '0;
      rx_byte   <= '0;
      rx_dc     <= 1'b0;
      rx_valid  <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], {io_reset, io_cs, io_dc, io_sdin, io_sclk}};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
      rx_valid  <= 1'b0;
      err_pulse <= 1'b0;
      if (!reset_n_s) begin
        bit_cnt <= '0;
      end else if (done) begin
        rx_byte  <= done_byte;
        rx_dc    <= done_dc;
        rx_valid <= 1'b1;
        bit_cnt  <= '0;
      end else if (cs_rise) begin
        err_pulse <= (bit_cnt != 3'd0);
        bit_cnt   <= '0;
      end else if (cs_fall) begin
        bit_cnt <= '0;
      end else if (shift_en) begin
        shreg   <= done_byte[6:0];
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

endmodule

// File: rtl/receptor_display.sv
// Display-side receiver: command decoder and framebuffer write addressing.
// Optional statistics counters enabled by defining RECEPTOR_STATS_EN.
module receptor_display
  import display_pkg::*;
#(
  parameter int unsigned COLS        = COLS_DEF,
  parameter int unsigned PAGES       = PAGES_DEF,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              io_sclk,
  input  logic              io_sdin,
  input  logic              io_cs,
  input  logic              io_dc,
  input  logic              io_reset,
  output logic [7:0]        rx_byte,
  output logic              rx_dc,
  output logic              rx_valid,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [7:0]        fb_wdata,
  output logic              display_on,
  output logic              frame_done,
  output logic              err_pulse,
  output logic [15:0]       byte_count,
  output logic [7:0]        frame_count
);

  localparam int unsigned CW = $clog2(COLS);
  localparam int unsigned PW = $clog2(PAGES);

  logic          reset_n_s, done, done_dc, des_err, dec_err;
  logic [7:0]    done_byte, cmd_q;
  logic [CW-1:0] col, col_start, col_end, arg0_q;
  logic [PW-1:0] page, page_start, page_end;
  logic [1:0]    args_left, arg_cnt;
  dec_state_t    state, state_n;
  logic          data_wr, abort, win_col, win_page, disp_set, disp_clr, arg_start, arg_store;

  spi_deserializador #(.SYNC_STAGES(SYNC_STAGES)) u_des (
    .clk       (clk),
    .rst       (rst),
    .io_sclk   (io_sclk),
    .io_sdin   (io_sdin),
    .io_cs     (io_cs),
    .io_dc     (io_dc),
    .io_reset  (io_reset),
    .reset_n_s (reset_n_s),
    .done      (done),
    .done_byte (done_byte),
    .done_dc   (done_dc),
    .rx_byte   (rx_byte),
    .rx_dc     (rx_dc),
    .rx_valid  (rx_valid),
    .err_pulse (des_err)
  );

  assign err_pulse = des_err | dec_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             state <= ST_CMD;
    else if (!reset_n_s) state <= ST_CMD;
    else                 state <= state_n;
  end

  always_comb begin
    state_n   = state;
    data_wr   = 1'b0;
    abort     = 1'b0;
    win_col   = 1'b0;
    win_page  = 1'b0;
    disp_set  = 1'b0;
    disp_clr  = 1'b0;
    arg_start = 1'b0;
    arg_store = 1'b0;
    arg_cnt   = '0;
    if (done) begin
      if (done_dc) begin
        data_wr = 1'b1;
        if (state == ST_ARG) begin
          abort   = 1'b1;
          state_n = ST_CMD;
        end
      end else if (state == ST_CMD) begin
        case (done_byte)
          OP_DISP_OFF: disp_clr = 1'b1;
          OP_DISP_ON:  disp_set = 1'b1;
          OP_COL_ADDR, OP_PAGE_ADDR: begin
            arg_start = 1'b1;
            arg_cnt   = 2'd2;
            state_n   = ST_ARG;
          end
          default: if (is_one_arg(done_byte)) begin
            arg_start = 1'b1;
            arg_cnt   = 2'd1;
            state_n   = ST_ARG;
          end
        endcase
      end else if (args_left == 2'd1) begin
        state_n  = ST_CMD;
        win_col  = (cmd_q == OP_COL_ADDR);
        win_page = (cmd_q == OP_PAGE_ADDR);
      end else begin
        arg_store = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fb_we      <= 1'b0;
      fb_addr    <= '0;
      fb_wdata   <= '0;
      display_on <= 1'b0;
      frame_done <= 1'b0;
      dec_err    <= 1'b0;
      col        <= '0;
      page       <= '0;
      col_start  <= '0;
      col_end    <= CW'(COLS - 1);
      page_start <= '0;
      page_end   <= PW'(PAGES - 1);
      cmd_q      <= '0;
      arg0_q     <= '0;
      args_left  <= '0;
    end else begin
      fb_we      <= 1'b0;
      frame_done <= 1'b0;
      dec_err    <= 1'b0;
      if (!reset_n_s) begin
        fb_addr    <= '0;
        fb_wdata   <= '0;
        display_on <= 1'b0;
        col        <= '0;
        page       <= '0;
        col_start  <= '0;
        col_end    <= CW'(COLS - 1);
        page_start <= '0;
        page_end   <= PW'(PAGES - 1);
        args_left  <= '0;
      end else begin
        if (arg_start) begin
          cmd_q     <= done_byte;
          args_left <= arg_cnt;
        end
        if (arg_store) begin
          arg0_q    <= done_byte[CW-1:0];
          args_left <= args_left - 2'd1;
        end
        if (disp_set) display_on <= 1'b1;
        if (disp_clr) display_on <= 1'b0;
        if (win_col) begin
          col_start <= arg0_q;
          col_end   <= done_byte[CW-1:0];
          col       <= arg0_q;
        end
        if (win_page) begin
          page_start <= arg0_q[PW-1:0];
          page_end   <= done_byte[PW-1:0];
          page       <= arg0_q[PW-1:0];
        end
        if (abort) dec_err <= 1'b1;
        // steps modulo COLS/PAGES so a start > end window wraps around
        if (data_wr) begin
          fb_we    <= 1'b1;
          fb_addr  <= ADDR_W'({page, col});
          fb_wdata <= done_byte;
          if (col == col_end) begin
            col <= col_start;
            if (page == page_end) begin
              page       <= page_start;
              frame_done <= 1'b1;
            end else begin
              page <= (page == PW'(PAGES - 1)) ? '0 : page + 1'b1;
            end
          end else begin
            col <= (col == CW'(COLS - 1)) ? '0 : col + 1'b1;
          end
        end
      end
    end
  end

`ifdef RECEPTOR_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_count  <= '0;
      frame_count <= '0;
    end else begin
      if (rx_valid)   byte_count  <= byte_count + 16'd1;
      if (frame_done) frame_count <= frame_count + 8'd1;
    end
  end
`else
  assign byte_count  = '0;
  assign frame_count = '0;
`endif

endmodule

// File: tb/tb_receptor_display.sv
// Scoreboard bench for receptor_display: stimulus pushes expected rx/fb events,
// a negedge monitor pops and compares them.
module tb_receptor_display;

  localparam int H = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        io_sclk = 1'b0, io_sdin = 1'b0, io_cs = 1'b1, io_dc = 1'b0, io_reset = 1'b1;
  logic [7:0]  rx_byte, fb_wdata, frame_count;
  logic        rx_dc, rx_valid, fb_we, display_on, frame_done, err_pulse;
  logic [9:0]  fb_addr;
  logic [15:0] byte_count;

  int total = 0, bad = 0;
  int n_rx = 0, n_err = 0, n_fd = 0;
  logic [8:0]  rxq[$];
  logic [18:0] fbq[$];

  receptor_display #(.COLS(128), .PAGES(8), .ADDR_W(10), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .io_sclk(io_sclk), .io_sdin(io_sdin), .io_cs(io_cs),
    .io_dc(io_dc), .io_reset(io_reset), .rx_byte(rx_byte), .rx_dc(rx_dc),
    .rx_valid(rx_valid), .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
    .display_on(display_on), .frame_done(frame_done), .err_pulse(err_pulse),
    .byte_count(byte_count), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rx_valid) begin
      n_rx++;
      if (rxq.size() == 0) check("rx_unexpected", {23'd0, rx_byte, rx_dc}, 32'h1FF);
      else check("rx", {23'd0, rx_byte, rx_dc}, {23'd0, rxq.pop_front()});
    end
    if (fb_we) begin
      if (fbq.size() == 0) check("fb_unexpected", {13'd0, fb_addr, fb_wdata, frame_done}, 32'h7FFFF);
      else check("fb", {13'd0, fb_addr, fb_wdata, frame_done}, {13'd0, fbq.pop_front()});
    end else if (frame_done) begin
      check("frame_done_without_we", 32'd1, 32'd0);
    end
    if (err_pulse) n_err++;
    if (frame_done) n_fd++;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] b, input logic dc, input int n, input bit cs_last);
    for (int k = 0; k < n; k++) begin
      io_sdin = b[7-k];
      io_dc   = dc;
      cyc(H);
      io_sclk = 1'b1;
      if (cs_last && k == n - 1) io_cs = 1'b1;
      cyc(H);
      io_sclk = 1'b0;
    end
    cyc(H + 3);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic dc);
    rxq.push_back({b, dc});
    send_bits(b, dc, 8, 1'b0);
  endtask

  task automatic send_data(input logic [7:0] b, input logic [9:0] addr, input logic fd);
    fbq.push_back({addr, b, fd});
    send_rx(b, 1'b1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rx0, err0, fd0;
    cyc(3);
    check("rst_rx_byte", {24'd0, rx_byte}, 32'd0);
    check("rst_fb_addr", {22'd0, fb_addr}, 32'd0);
    check("rst_flags", {26'd0, rx_valid, fb_we, display_on, frame_done, err_pulse, rx_dc}, 32'd0);
    check("rst_stats", {8'd0, byte_count, frame_count}, 32'd0);
    rst = 1'b0;
    cyc(2);

    // single data byte into the reset pointer
    io_cs = 1'b0;
    cyc(6);
    rx0 = n_rx;
    send_data(8'hA5, 10'd0, 1'b0);
    check("t1_rx_count", n_rx - rx0, 32'd1);

    // window 16..17 x pages 2..3
    send_rx(8'h21, 1'b0); send_rx(8'h10, 1'b0); send_rx(8'h11, 1'b0);
    send_rx(8'h22, 1'b0); send_rx(8'h02, 1'b0); send_rx(8'h03, 1'b0);
    fd0 = n_fd;
    send_data(8'h11, 10'd272, 1'b0);
    send_data(8'h12, 10'd273, 1'b0);
    send_data(8'h13, 10'd400, 1'b0);
    send_data(8'h14, 10'd401, 1'b1);
    send_data(8'h15, 10'd272, 1'b0);
    check("t2_frame_done", n_fd - fd0, 32'd1);

    // partial byte then display on, last edge coinciding with cs release
    io_cs = 1'b1; cyc(6); io_cs = 1'b0; cyc(6);
    rx0 = n_rx; err0 = n_err;
    send_bits(8'hFF, 1'b0, 5, 1'b0);
    io_cs = 1'b1;
    cyc(8);
    check("t3_err", n_err - err0, 32'd1);
    check("t3_no_rx", n_rx - rx0, 32'd0);
    io_cs = 1'b0; cyc(6);
    err0 = n_err;
    rxq.push_back({8'hAF, 1'b0});
    send_bits(8'hAF, 1'b0, 8, 1'b1);
    check("t3_display_on", {31'd0, display_on}, 32'd1);
    check("t3_cs_edge_no_err", n_err - err0, 32'd0);
    io_cs = 1'b0; cyc(6);

    // aborted column command: pointer was {2,17}
    err0 = n_err;
    send_rx(8'h21, 1'b0); send_rx(8'h05, 1'b0);
    send_data(8'h3C, 10'd273, 1'b0);
    check("t4_abort_err", n_err - err0, 32'd1);
    send_data(8'h77, 10'd400, 1'b0);

    // full frame after reset
    rst = 1'b1; cyc(2); rst = 1'b0; cyc(6);
    fd0 = n_fd;
    for (int i = 0; i < 1024; i++)
      send_data(8'(i), 10'(i), i == 1023);
    check("t5_frame_done_once", n_fd - fd0, 32'd1);
`ifdef RECEPTOR_STATS_EN
    check("t5_byte_count", {16'd0, byte_count}, 32'd1024);
    check("t5_frame_count", {24'd0, frame_count}, 32'd1);
`else
    check("t5_byte_count", {16'd0, byte_count}, 32'd0);
    check("t5_frame_count", {24'd0, frame_count}, 32'd0);
`endif

    // display reset mid-frame
    send_data(8'h01, 10'd0, 1'b0);
    send_data(8'h02, 10'd1, 1'b0);
    send_data(8'h03, 10'd2, 1'b0);
    send_rx(8'hAF, 1'b0);
    check("t6_on_before", {31'd0, display_on}, 32'd1);
    io_reset = 1'b0;
    cyc(10);
    check("t6_ioreset_display_off", {31'd0, display_on}, 32'd0);
    check("t6_ioreset_fb_addr", {22'd0, fb_addr}, 32'd0);
    check("t6_ioreset_rx_hold", {23'd0, rx_byte, rx_dc}, {23'd0, 8'hAF, 1'b0});
`ifdef RECEPTOR_STATS_EN
    check("t6_ioreset_stats_hold", {16'd0, byte_count}, 32'd1028);
`else
    check("t6_ioreset_stats_hold", {16'd0, byte_count}, 32'd0);
`endif
    io_reset = 1'b1;
    cyc(6);
    send_data(8'h99, 10'd0, 1'b0);
    send_rx(8'hAF, 1'b0);
    send_bits(8'hF0, 1'b1, 4, 1'b0);
    rst = 1'b1;
    #1;
    check("t6_rst_rx_byte", {24'd0, rx_byte}, 32'd0);
    check("t6_rst_display", {31'd0, display_on}, 32'd0);
    check("t6_rst_fb", {14'd0, fb_addr, fb_wdata}, 32'd0);
    check("t6_rst_stats", {8'd0, byte_count, frame_count}, 32'd0);
    cyc(3);
    rst = 1'b0;
    cyc(10);
    check("rxq_drained", rxq.size(), 32'd0);
    check("fbq_drained", fbq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
